sqr_param_meas: RTL and testbench



---
 rtl/sqr_meas_pkg.sv | 20 ++
 rtl/sqr_schmitt_edge.sv | 48 ++++
 rtl/sqr_param_meas.sv | 251 +++++++++++++++++++++++++
 tb/tb_sqr_param_meas.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sqr_meas_pkg.sv
// Shared definitions for the square-wave parameter measurement block:
// FSM encoding, default widths/hysteresis and the full-scale level constant.
package sqr_meas_pkg;

  localparam int unsigned DT_W_DEF    = 8;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned WIN_LEN_DEF = 4096;
  localparam int unsigned HYST_DEF    = 8;

  localparam logic [DT_W_DEF-1:0] MAX_LVL = {DT_W_DEF{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PEAK = 3'd1,
    S_ARM  = 3'd2,
    S_MEAS = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sqr_schmitt_edge.sv
// Hysteresis comparator: level register with force-high load and a
// same-cycle rising-edge pulse for the sample that sets the level.
module sqr_schmitt_edge #(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            din_valid_i,
  input  logic            force_hi_i,
  input  logic [DT_W-1:0] din_i,
  input  logic [DT_W-1:0] thr_hi_i,
  input  logic [DT_W-1:0] thr_lo_i,
  output logic            rise_o
);

  logic lvl_q, lvl_d;
  logic above_s, below_s, upd_s;

  assign above_s = (din_i >= thr_hi_i);
  assign below_s = (din_i <= thr_lo_i);
  assign upd_s   = en_i && din_valid_i;
  assign rise_o  = upd_s && !lvl_q && above_s;

  // next level: forced high on load, otherwise Schmitt update on valid samples
  always_comb begin
    lvl_d = lvl_q;
    if (force_hi_i) begin
      lvl_d = 1'b1;
    end else if (upd_s && above_s) begin
      lvl_d = 1'b1;
    end else if (upd_s && below_s) begin
      lvl_d = 1'b0;
    end else begin
      lvl_d = lvl_q;
    end
  end

  // level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/sqr_param_meas.sv
// Square-wave parameter measurement: peak/trough over a window, then period
// between rising edges. Define SQR_MEAS_AVG_EN to average over 4 periods.
module sqr_param_meas
  import sqr_meas_pkg::*;
#(
  parameter int unsigned DT_W    = DT_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned WIN_LEN = WIN_LEN_DEF,
  parameter int unsigned HYST    = HYST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din_valid,
  input  logic [DT_W-1:0]  din,
  output logic             busy,
  output logic             meas_valid,
  output logic [DT_W-1:0]  amplitude,
  output logic [DT_W-1:0]  trough,
  output logic [CNT_W-1:0] period,
  output logic [DT_W-1:0]  cycle_num,
  output logic             err
);

  localparam int unsigned WC_W  = $clog2(WIN_LEN + 1);
  localparam int unsigned SUM_W = CNT_W + 2;
`ifdef SQR_MEAS_AVG_EN
  localparam int unsigned NPER = 4;
`else
  localparam int unsigned NPER = 1;
`endif
  localparam logic [DT_W-1:0]  LVL_MAX   = {DT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_MAX    = {CNT_W{1'b1}};
  localparam logic [DT_W-1:0]  HYST_V    = DT_W'(HYST);
  localparam logic [DT_W+1:0]  HYST_EXT  = (DT_W + 2)'(HYST);
  localparam logic [DT_W:0]    HYST2     = (DT_W + 1)'(2 * HYST);
  localparam logic [1:0]       ECNT_LAST = 2'(NPER - 1);

  function automatic logic [DT_W-1:0] sat_lvl(input logic [CNT_W-1:0] v);
    sat_lvl = (v > CNT_W'(LVL_MAX)) ? LVL_MAX : v[DT_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [DT_W-1:0]   max_q, max_d, min_q, min_d;
  logic [WC_W-1:0]   win_q, win_d;
  logic [DT_W-1:0]   thr_hi_q, thr_hi_d, thr_lo_q, thr_lo_d;
  logic [CNT_W-1:0]  per_q, per_d, to_q, to_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [1:0]        ecnt_q, ecnt_d;
  logic              busy_q, mv_q, err_q;
  logic [DT_W-1:0]   amp_q, tr_q, cyc_q;
  logic [CNT_W-1:0]  period_q;

  logic [DT_W-1:0]   nmax_s, nmin_s, mid_s, thr_hi_s, thr_lo_s, range_s;
  logic [DT_W:0]     sum9_s;
  logic [DT_W+1:0]   hi_ext_s;
  logic              win_last_s, flat_s, arm_load_s, rise_s, en_s, to_last_s;
  logic [CNT_W-1:0]  to_inc_s, avg_per_s, res_per_s;
  logic [SUM_W-1:0]  sum_nx_s;
  logic              res_err_s;

  assign nmax_s     = (din > max_q) ? din : max_q;
  assign nmin_s     = (din < min_q) ? din : min_q;
  assign sum9_s     = {1'b0, nmax_s} + {1'b0, nmin_s};
  assign mid_s      = DT_W'(sum9_s >> 1);
  assign hi_ext_s   = {2'b00, mid_s} + HYST_EXT;
  assign thr_hi_s   = (hi_ext_s > {2'b00, LVL_MAX}) ? LVL_MAX : hi_ext_s[DT_W-1:0];
  assign thr_lo_s   = (mid_s >= HYST_V) ? (mid_s - HYST_V) : {DT_W{1'b0}};
  assign range_s    = nmax_s - nmin_s;
  assign flat_s     = ({1'b0, range_s} <= HYST2);
  assign win_last_s = (win_q == WC_W'(WIN_LEN - 1));
  assign arm_load_s = (state_q == S_PEAK) && din_valid && win_last_s && !flat_s;
  assign en_s       = (state_q == S_ARM) || (state_q == S_MEAS);
  assign to_inc_s   = (to_q == TO_MAX) ? to_q : (to_q + 1'b1);
  assign to_last_s  = (to_q >= (TO_MAX - 1'b1));
  assign sum_nx_s   = sum_q + SUM_W'(per_q) + SUM_W'(1);
`ifdef SQR_MEAS_AVG_EN
  assign avg_per_s  = CNT_W'(sum_nx_s >> 2);
`else
  assign avg_per_s  = CNT_W'(sum_nx_s);
`endif

  sqr_schmitt_edge #(.DT_W(DT_W)) u_schmitt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_s),
    .din_valid_i(din_valid),
    .force_hi_i (arm_load_s),
    .din_i      (din),
    .thr_hi_i   (thr_hi_q),
    .thr_lo_i   (thr_lo_q),
    .rise_o     (rise_s)
  );

  // next-state and datapath updates; an edge always takes priority over timeout
  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    win_d     = win_q;
    thr_hi_d  = thr_hi_q;
    thr_lo_d  = thr_lo_q;
    per_d     = per_q;
    to_d      = to_q;
    sum_d     = sum_q;
    ecnt_d    = ecnt_q;
    res_per_s = {CNT_W{1'b0}};
    res_err_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          max_d   = {DT_W{1'b0}};
          min_d   = LVL_MAX;
          win_d   = {WC_W{1'b0}};
          state_d = S_PEAK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PEAK: begin
        if (din_valid) begin
          max_d = nmax_s;
          min_d = nmin_s;
          win_d = win_q + 1'b1;
          if (win_last_s) begin
            thr_hi_d = thr_hi_s;
            thr_lo_d = thr_lo_s;
            to_d     = {CNT_W{1'b0}};
            if (flat_s) begin
              res_err_s = 1'b1;
              state_d   = S_DONE;
            end else begin
              state_d = S_ARM;
            end
          end else begin
            state_d = S_PEAK;
          end
        end else begin
          state_d = S_PEAK;
        end
      end
      S_ARM: begin
        if (din_valid) begin
          to_d = to_inc_s;
          if (rise_s) begin
            per_d   = {CNT_W{1'b0}};
            sum_d   = {SUM_W{1'b0}};
            ecnt_d  = 2'd0;
            state_d = S_MEAS;
          end else if (to_last_s) begin
            res_err_s = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_ARM;
          end
        end else begin
          state_d = S_ARM;
        end
      end
      S_MEAS: begin
        if (din_valid) begin
          to_d = to_inc_s;
          if (rise_s) begin
            per_d  = {CNT_W{1'b0}};
            sum_d  = sum_nx_s;
            ecnt_d = ecnt_q + 1'b1;
            if (ecnt_q == ECNT_LAST) begin
              res_per_s = avg_per_s;
              state_d   = S_DONE;
            end else begin
              state_d = S_MEAS;
            end
          end else if (to_last_s) begin
            res_err_s = 1'b1;
            state_d   = S_DONE;
          end else begin
            per_d   = per_q + 1'b1;
            state_d = S_MEAS;
          end
        end else begin
          state_d = S_MEAS;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and measurement datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      max_q    <= {DT_W{1'b0}};
      min_q    <= {DT_W{1'b0}};
      win_q    <= {WC_W{1'b0}};
      thr_hi_q <= {DT_W{1'b0}};
      thr_lo_q <= {DT_W{1'b0}};
      per_q    <= {CNT_W{1'b0}};
      to_q     <= {CNT_W{1'b0}};
      sum_q    <= {SUM_W{1'b0}};
      ecnt_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      min_q    <= min_d;
      win_q    <= win_d;
      thr_hi_q <= thr_hi_d;
      thr_lo_q <= thr_lo_d;
      per_q    <= per_d;
      to_q     <= to_d;
      sum_q    <= sum_d;
      ecnt_q   <= ecnt_d;
    end
  end

  // result registers: loaded on entry to DONE, which is also the strobe cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      mv_q     <= 1'b0;
      err_q    <= 1'b0;
      amp_q    <= {DT_W{1'b0}};
      tr_q     <= {DT_W{1'b0}};
      cyc_q    <= {DT_W{1'b0}};
      period_q <= {CNT_W{1'b0}};
    end else begin
      busy_q <= (state_d != S_IDLE);
      mv_q   <= (state_d == S_DONE);
      if (state_d == S_DONE) begin
        amp_q    <= max_d;
        tr_q     <= min_d;
        period_q <= res_per_s;
        cyc_q    <= sat_lvl(res_per_s >> 1);
        err_q    <= res_err_s;
      end else if ((state_q == S_IDLE) && start) begin
        err_q <= 1'b0;
      end else begin
        err_q <= err_q;
      end
    end
  end

  assign busy       = busy_q;
  assign meas_valid = mv_q;
  assign amplitude  = amp_q;
  assign trough     = tr_q;
  assign period     = period_q;
  assign cycle_num  = cyc_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sqr_param_meas.sv
// Bench for sqr_param_meas: directed table, reset-abort sequence and random
// square waves checked against a sample-list reference model.
module tb_sqr_param_meas;

  localparam int WIN    = 64;
  localparam int HY     = 8;
  localparam int TO_LIM = 65535;
`ifdef SQR_MEAS_AVG_EN
  localparam int NP = 4;
`else
  localparam int NP = 1;
`endif

  typedef struct {
    int hi, lo, nhi, nlo, phase, glitch, gap, extra, junk;
    int e_amp, e_tr, e_per, e_cyc, e_err;
  } vec_t;

  typedef struct {
    int amp, tr, per, cyc, err, used;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        din_valid = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        busy, meas_valid, err;
  logic [7:0]  amplitude, trough, cycle_num;
  logic [15:0] period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqr_param_meas #(.DT_W(8), .CNT_W(16), .WIN_LEN(WIN), .HYST(HY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din_valid(din_valid), .din(din),
    .busy(busy), .meas_valid(meas_valid), .amplitude(amplitude), .trough(trough),
    .period(period), .cycle_num(cycle_num), .err(err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sample i (0-based, counting only valid samples after start) of a vector.
  function automatic int smp(vec_t v, int i);
    int k;
    k = (i + v.phase) % (v.nhi + v.nlo);
    if (v.glitch != 0 && (k == 3 || k == v.nhi + 3)) return 120 + (i % 11);
    return (k < v.nhi) ? v.hi : v.lo;
  endfunction

  // Reference: window extremes, Schmitt edges over the sample list, timeout.
  function automatic exp_t model(vec_t v);
    exp_t e;
    int mx, mn, mid, thi, tlo, lvl, prev, edges, first, s, j;
    mx = 0; mn = 255; edges = 0; first = 0;
    for (int i = 0; i < WIN; i++) begin
      s = smp(v, i);
      if (s > mx) mx = s;
      if (s < mn) mn = s;
    end
    e.amp = mx; e.tr = mn; e.per = 0; e.err = 0; e.cyc = 0; e.used = WIN;
    if (mx - mn <= 2 * HY) begin
      e.err = 1;
      return e;
    end
    mid = (mx + mn) / 2;
    thi = (mid + HY > 255) ? 255 : mid + HY;
    tlo = (mid < HY) ? 0 : mid - HY;
    lvl = 1;
    for (j = 1; j <= TO_LIM + 10; j++) begin
      s = smp(v, WIN + j - 1);
      prev = lvl;
      if (s >= thi) lvl = 1;
      else if (s <= tlo) lvl = 0;
      if (lvl == 1 && prev == 0) begin
        if (edges == 0) first = j;
        edges++;
        if (edges == NP + 1) begin
          e.per = (j - first) / NP;
          break;
        end
      end else if (j >= TO_LIM) begin
        e.err = 1;
        break;
      end
    end
    e.used = WIN + j;
    e.cyc  = (e.per / 2 > 255) ? 255 : e.per / 2;
    return e;
  endfunction

  task automatic run_meas(input vec_t v, input string tag);
    exp_t e;
    int idx, cyc, got, idle_seen, budget, valid;
    e = model(v);
    if (v.e_amp >= 0) begin
      e.amp = v.e_amp; e.tr = v.e_tr; e.per = v.e_per; e.cyc = v.e_cyc; e.err = v.e_err;
    end
    idx = 0; cyc = 0; got = 0; idle_seen = 0;
    budget = 2 * e.used + 500;
    start = 1'b1; din_valid = 1'b1; din = 8'(v.junk);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy), 1);
    while (got == 0 && cyc < budget) begin
      case (v.gap)
        0:       valid = 1;
        1:       valid = (cyc % 2 == 0) ? 1 : 0;
        default: valid = ($urandom_range(3, 0) != 0) ? 1 : 0;
      endcase
      start = (v.extra > 0 && cyc == v.extra) ? 1'b1 : 1'b0;
      if (valid != 0) begin
        din_valid = 1'b1; din = 8'(smp(v, idx)); idx++;
      end else begin
        din_valid = 1'b0; din = 8'($urandom_range(255, 0));
      end
      @(posedge clk); #1;
      cyc++;
      if (meas_valid) got = 1;
      else if (!busy) idle_seen++;
    end
    start = 1'b0; din_valid = 1'b0;
    chk({tag, "_strobe_seen"}, got, 1);
    chk({tag, "_busy_held"}, idle_seen, 0);
    if (got != 0) begin
      chk({tag, "_amplitude"}, int'(amplitude), e.amp);
      chk({tag, "_trough"}, int'(trough), e.tr);
      chk({tag, "_period"}, int'(period), e.per);
      chk({tag, "_cycle_num"}, int'(cycle_num), e.cyc);
      chk({tag, "_err"}, int'(err), e.err);
      chk({tag, "_samples_used"}, idx, e.used);
    end
    @(posedge clk); #1;
    chk({tag, "_strobe_single"}, int'(meas_valid), 0);
    chk({tag, "_busy_drop"}, int'(busy), 0);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    //         hi   lo   nhi     nlo  phase glt gap extra junk   amp  tr   per cyc err
    tbl[0] = '{200, 50,  10,     10,  0,      0, 0, 0,   255,   200, 50,  20, 10, 0};
    tbl[1] = '{128, 128, 10,     10,  0,      0, 0, 0,   0,     128, 128, 0,  0,  1};
    tbl[2] = '{220, 30,  300,    300, 270,    0, 0, 0,   255,   220, 30,  600, 255, 0};
    tbl[3] = '{200, 50,  100000, 32,  100000, 0, 0, 0,   0,     200, 50,  0,  0,  1};
    tbl[4] = '{200, 50,  10,     10,  0,      0, 1, 170, 255,   200, 50,  20, 10, 0};
    tbl[5] = '{200, 50,  10,     10,  0,      1, 2, 0,   0,     200, 50,  20, 10, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_meas_valid", int'(meas_valid), 0);
    chk("reset_amplitude", int'(amplitude), 0);
    chk("reset_trough", int'(trough), 0);
    chk("reset_period", int'(period), 0);
    chk("reset_cycle_num", int'(cycle_num), 0);
    chk("reset_err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      run_meas(tbl[t], $sformatf("vec%0d", t));
    end

    // abort in the middle of the period count, then repeat the basic case
    start = 1'b1; din_valid = 1'b1; din = 8'd255;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 90; i++) begin
      din = 8'(smp(tbl[0], i));
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_amplitude", int'(amplitude), 0);
    chk("abort_trough", int'(trough), 0);
    chk("abort_period", int'(period), 0);
    chk("abort_cycle_num", int'(cycle_num), 0);
    chk("abort_err", int'(err), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_strobe", int'(meas_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_meas(tbl[0], "after_abort");

    for (int r = 0; r < 8; r++) begin
      rv.hi     = $urandom_range(255, 0);
      rv.lo     = $urandom_range(255, 0);
      rv.nhi    = $urandom_range(40, 3);
      rv.nlo    = $urandom_range(40, 3);
      rv.phase  = $urandom_range(79, 0);
      rv.glitch = 0;
      rv.gap    = $urandom_range(2, 0);
      rv.extra  = 0;
      rv.junk   = $urandom_range(255, 0);
      rv.e_amp  = -1; rv.e_tr = -1; rv.e_per = -1; rv.e_cyc = -1; rv.e_err = -1;
      run_meas(rv, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
